sparrow_dmem_axil_bridge: RTL

// - Sits downstream of the core data-memory port. Turns each single-beat core load/store into one
//   AXI4-Lite transaction, so data memory may have arbitrary latency.
// - Holds the core with o_core_stall until the bus response returns.
// - Returns the raw 32-bit read word plus an error flag. Lane extraction and sign/zero extension

---
 rtl/sparrow_pkg.sv | 40 ++++
 rtl/sparrow_dmem_lane_align.sv | 32 +++
 rtl/sparrow_dmem_axil_bridge.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sparrow_pkg.sv
// Shared types for the sparrow data-memory path: access sizes, AXI responses
// and the AXI4-Lite bridge FSM states.
package sparrow_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } dmem_size_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } dmem_bridge_state_e;

    // The core encodes size as a byte-enable code; 2'b10 is treated as a word.
    function automatic dmem_size_e size_from_byte_en(input logic [1:0] byte_en);
        case (byte_en)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (axi_resp_e'(resp) == SLVERR) || (axi_resp_e'(resp) == DECERR);
    endfunction

endpackage

// File: rtl/sparrow_dmem_lane_align.sv
// Combinational store-lane alignment: replicates right-aligned store data across
// the word, builds the byte strobe and flags misaligned half/word accesses.
module sparrow_dmem_lane_align
    import sparrow_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wr_data,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_wstrb      = 4'hF;
        o_wdata      = i_wr_data;
        o_misaligned = 1'b0;
        case (dmem_size_e'(i_size))
            BYTE: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wr_data[7:0]}};
            end
            HALF: begin
                o_wstrb      = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wr_data[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            default: o_misaligned = |i_addr_lo;
        endcase
    end

endmodule

// File: rtl/sparrow_dmem_axil_bridge.sv
// Converts single-beat core loads/stores into AXI4-Lite transactions, stalling
// the core until the response returns; DONE presents the raw word and error flag.
module sparrow_dmem_axil_bridge
    import sparrow_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_core_req,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [1:0]        i_core_byte_en,
    input  logic              i_core_wr_en,
    input  logic [DATA_W-1:0] i_core_wr_data,
    output logic [DATA_W-1:0] o_core_rd_data,
    output logic              o_core_stall,
    output logic              o_core_err,
    output logic              o_axi_awvalid,
    input  logic              i_axi_awready,
    output logic [ADDR_W-1:0] o_axi_awaddr,
    output logic              o_axi_wvalid,
    input  logic              i_axi_wready,
    output logic [DATA_W-1:0] o_axi_wdata,
    output logic [3:0]        o_axi_wstrb,
    input  logic              i_axi_bvalid,
    output logic              o_axi_bready,
    input  logic [1:0]        i_axi_bresp,
    output logic              o_axi_arvalid,
    input  logic              i_axi_arready,
    output logic [ADDR_W-1:0] o_axi_araddr,
    input  logic              i_axi_rvalid,
    output logic              o_axi_rready,
    input  logic [DATA_W-1:0] i_axi_rdata,
    input  logic [1:0]        i_axi_rresp
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("sparrow_dmem_axil_bridge supports DATA_W = 32 only");
        end
    endgenerate

    dmem_bridge_state_e state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               err_q, err_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;

    logic [1:0]         req_size;
    logic [3:0]         al_wstrb;
    logic [31:0]        al_wdata;
    logic               al_misaligned;

    assign req_size = size_from_byte_en(i_core_byte_en);

    sparrow_dmem_lane_align u_lane_align (
        .i_size       (req_size),
        .i_addr_lo    (i_core_addr[1:0]),
        .i_wr_data    (i_core_wr_data),
        .o_wstrb      (al_wstrb),
        .o_wdata      (al_wdata),
        .o_misaligned (al_misaligned)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        wstrb_d   = wstrb_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: if (i_core_req) begin
                addr_d    = i_core_addr;
                wdata_d   = al_wdata;
                wstrb_d   = al_wstrb;
                rd_data_d = '0;
                err_d     = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (al_misaligned) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (i_core_wr_en) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_WR_REQ;
                end else begin
                    arvalid_d = 1'b1;
                    state_d   = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: if (i_axi_arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = ST_RD_DATA;
            end
            ST_RD_DATA: if (i_axi_rvalid) begin
                rready_d  = 1'b0;
                rd_data_d = i_axi_rdata;
                err_d     = resp_is_err(i_axi_rresp);
                state_d   = ST_DONE;
            end
            ST_WR_REQ: begin
                // AW and W complete independently; either may finish first or both together.
                if (awvalid_q && i_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && i_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (i_axi_bvalid) begin
                bready_d = 1'b0;
                err_d    = resp_is_err(i_axi_bresp);
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            wstrb_q   <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            wstrb_q   <= wstrb_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Low in DONE so the core retires on that edge.
    assign o_core_stall = (state_q == ST_IDLE) ? i_core_req : (state_q != ST_DONE);

    assign o_core_rd_data = rd_data_q;
    assign o_core_err     = err_q;
    assign o_axi_awvalid  = awvalid_q;
    assign o_axi_awaddr   = addr_q;
    assign o_axi_wvalid   = wvalid_q;
    assign o_axi_wdata    = wdata_q;
    assign o_axi_wstrb    = wstrb_q;
    assign o_axi_bready   = bready_q;
    assign o_axi_arvalid  = arvalid_q;
    assign o_axi_araddr   = addr_q;
    assign o_axi_rready   = rready_q;

endmodule
